lab8_sysid_arbiter: RTL and testbench

Shares the single-port, combinational system-ID slave between two Avalon-MM read masters (m0 = Nios II data master, m1 = debug/JTAG master) with round-robin arbitration and a fixed-latency pipelined read response. After every reset, it runs a hardware boot check that reads ID and timestamp, compares them to expected values, and flags mismatch before granting any master. Sits in the lab8 SoC between the interconnect-facing master ports and the sysid slave.

---
 rtl/lab8_sysid_arbiter.sv | 175 +++++++++++++++++
 tb/tb_lab8_sysid_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab8_sysid_arbiter.sv
// Round-robin arbiter sharing the combinational sysid slave between two Avalon-MM read masters.
// Optional post-reset ID/timestamp boot check is enabled by defining SYSID_ARB_BOOTCHK_EN.
module lab8_sysid_arbiter #(
  parameter logic [31:0] EXP_ID = 32'd0,
  parameter logic [31:0] EXP_TS = 32'd1476553823
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        s_address,
  input  logic [31:0] s_readdata,
  output logic        boot_done,
  output logic        id_ok,
  output logic        id_mismatch
);

`ifdef SYSID_ARB_BOOTCHK_EN
  typedef enum logic [2:0] {BOOT_ID, BOOT_TS, BOOT_CHK, IDLE, BUSY, RESP} state_t;
  localparam state_t RESET_STATE = BOOT_ID;
`else
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_reg, state_next;
  logic              s_address_reg, s_address_next;
  // last_grant doubles as the owner of the transfer in flight
  logic              last_grant_reg, last_grant_next;
  logic [1:0][31:0]  rdata_reg, rdata_next;
  logic [1:0]        valid_reg, valid_next;

  logic [1:0]        req;
  logic [1:0]        addr;
  logic [1:0]        wait_vec;
  logic              winner;
  logic              grant_valid;

  assign req  = {m1_read, m0_read};
  assign addr = {m1_address, m0_address};

  // Tie goes to the master that did not win last; reset_n gating keeps waitrequest high during reset.
  assign winner      = req[1] & (~req[0] | ~last_grant_reg);
  assign grant_valid = reset_n & (state_reg == IDLE) & (|req);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wait
      assign wait_vec[gi] = ~(grant_valid & (winner == 1'(gi)));
    end
  endgenerate

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdata      = rdata_reg[0];
  assign m1_readdata      = rdata_reg[1];
  assign m0_readdatavalid = valid_reg[0];
  assign m1_readdatavalid = valid_reg[1];
  assign s_address        = s_address_reg;

`ifdef SYSID_ARB_BOOTCHK_EN
  logic [31:0] id_q_reg, id_q_next;
  logic [31:0] ts_q_reg, ts_q_next;
  logic        boot_done_reg, boot_done_next;
  logic        id_ok_reg, id_ok_next;
  logic        id_mismatch_reg, id_mismatch_next;
  logic        match;

  assign match       = (id_q_reg == EXP_ID) && (ts_q_reg == EXP_TS);
  assign boot_done   = boot_done_reg;
  assign id_ok       = id_ok_reg;
  assign id_mismatch = id_mismatch_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q_reg        <= '0;
      ts_q_reg        <= '0;
      boot_done_reg   <= 1'b0;
      id_ok_reg       <= 1'b0;
      id_mismatch_reg <= 1'b0;
    end else begin
      id_q_reg        <= id_q_next;
      ts_q_reg        <= ts_q_next;
      boot_done_reg   <= boot_done_next;
      id_ok_reg       <= id_ok_next;
      id_mismatch_reg <= id_mismatch_next;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^{EXP_ID, EXP_TS};
  assign boot_done   = 1'b1;
  assign id_ok       = 1'b0;
  assign id_mismatch = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= RESET_STATE;
      s_address_reg  <= 1'b0;
      last_grant_reg <= 1'b1;
      rdata_reg      <= '0;
      valid_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      s_address_reg  <= s_address_next;
      last_grant_reg <= last_grant_next;
      rdata_reg      <= rdata_next;
      valid_reg      <= valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    s_address_next  = s_address_reg;
    last_grant_next = last_grant_reg;
    rdata_next      = rdata_reg;
    valid_next      = '0;
`ifdef SYSID_ARB_BOOTCHK_EN
    id_q_next        = id_q_reg;
    ts_q_next        = ts_q_reg;
    boot_done_next   = boot_done_reg;
    id_ok_next       = id_ok_reg;
    id_mismatch_next = id_mismatch_reg;
`endif
    case (state_reg)
`ifdef SYSID_ARB_BOOTCHK_EN
      BOOT_ID: begin
        id_q_next      = s_readdata;
        s_address_next = 1'b1;
        state_next     = BOOT_TS;
      end
      BOOT_TS: begin
        ts_q_next  = s_readdata;
        state_next = BOOT_CHK;
      end
      BOOT_CHK: begin
        boot_done_next   = 1'b1;
        id_ok_next       = match;
        id_mismatch_next = ~match;
        state_next       = IDLE;
      end
`endif
      IDLE: begin
        if (grant_valid) begin
          last_grant_next = winner;
          s_address_next  = addr[winner];
          state_next      = BUSY;
        end
      end
      BUSY: begin
        // Data and strobe are registered together so both appear in RESP.
        rdata_next[last_grant_reg] = s_readdata;
        valid_next[last_grant_reg] = 1'b1;
        state_next                 = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

endmodule

// File: tb/tb_lab8_sysid_arbiter.sv
// Scoreboard bench for lab8_sysid_arbiter: directed reads push expected responses, a monitor checks them.
module tb_lab8_sysid_arbiter;
  localparam logic [31:0] TS_VAL = 32'd1476553823;
`ifdef SYSID_ARB_BOOTCHK_EN
  localparam int   BOOT_CYC      = 3;
  localparam logic RST_BOOT_DONE = 1'b0;
`else
  localparam int   BOOT_CYC      = 0;
  localparam logic RST_BOOT_DONE = 1'b1;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_read = 1'b0, m0_address = 1'b0;
  logic        m1_read = 1'b0, m1_address = 1'b0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_address;
  logic [31:0] s_readdata;
  logic        boot_done, id_ok, id_mismatch;
  logic [31:0] id_val = 32'd0;

  lab8_sysid_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_readdata(s_readdata),
    .boot_done(boot_done), .id_ok(id_ok), .id_mismatch(id_mismatch)
  );

  assign s_readdata = s_address ? TS_VAL : id_val;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          m;
    logic [31:0] data;
    int          at;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] exp_rd [2];
  resp_t       mon_r;
  bit          mon_m;

  // Monitor: pops one expected response for every readdatavalid strobe.
  always @(negedge clock) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (m0_readdatavalid && m1_readdatavalid) begin
        check("both_valid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd1);
      end else if (sb.size() == 0) begin
        check("unexpected_valid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      end else begin
        mon_r = sb.pop_front();
        mon_m = m1_readdatavalid;
        check("resp_master", 32'(mon_m), 32'(mon_r.m));
        check("resp_cycle", 32'(cyc), 32'(mon_r.at));
        check("resp_data", mon_m ? m1_readdata : m0_readdata, mon_r.data);
        check("nonowner_hold", mon_m ? m0_readdata : m1_readdata, exp_rd[~mon_m]);
        exp_rd[mon_m] = mon_r.data;
        $display("resp m%0d data=%h cycle=%0d", mon_m, mon_m ? m1_readdata : m0_readdata, cyc);
      end
    end
  end

  // Called at a negedge; returns at a negedge after the transfer edge.
  task automatic do_read(input bit m, input bit a, input logic [31:0] exp_data, output int acc);
    int n;
    n = 0;
    if (m) begin m1_read = 1'b1; m1_address = a; end
    else   begin m0_read = 1'b1; m0_address = a; end
    #1;
    while ((m ? m1_waitrequest : m0_waitrequest) && n < 60) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL wait_timeout: m%0d never accepted, required acceptance within 60 cycles", m);
      acc = -1;
    end else begin
      acc = cyc;
      check("other_wait_high", 32'(m ? m0_waitrequest : m1_waitrequest), 32'd1);
      sb.push_back('{m, exp_data, cyc + 2});
      $display("req  m%0d addr=%0d accepted cycle=%0d", m, a, cyc);
    end
    @(posedge clock); #1;
    if (m) m1_read = 1'b0; else m0_read = 1'b0;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    m0_read = 1'b1; m0_address = 1'b0; m1_read = 1'b0;
    #1;
    check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    check("rst_m0_data", m0_readdata, 32'd0);
    check("rst_m1_data", m1_readdata, 32'd0);
    check("rst_valid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
    check("rst_s_addr", 32'(s_address), 32'd0);
    check("rst_boot_done", 32'(boot_done), 32'(RST_BOOT_DONE));
    check("rst_flags", 32'({id_ok, id_mismatch}), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Releases reset with m0 requesting address 0; that read must wait out the boot check.
  task automatic boot_seq(input bit exp_ok);
    int rel;
    rel = cyc;
    reset_n = 1'b1;
    for (int k = 0; k < BOOT_CYC; k++) begin
      #1;
      check("boot_wait_m0", 32'(m0_waitrequest), 32'd1);
      check("boot_wait_m1", 32'(m1_waitrequest), 32'd1);
      check("boot_not_done", 32'(boot_done), 32'd0);
      @(negedge clock);
    end
    #1;
    check("boot_done", 32'(boot_done), 32'd1);
`ifdef SYSID_ARB_BOOTCHK_EN
    check("boot_flags", 32'({id_ok, id_mismatch}), exp_ok ? 32'd2 : 32'd1);
`else
    check("boot_flags", 32'({id_ok, id_mismatch}), 32'd0);
    if (exp_ok) begin end
`endif
    check("first_grant_cycle", 32'(cyc - rel), 32'(BOOT_CYC));
    check("first_grant_wait", 32'(m0_waitrequest), 32'd0);
    sb.push_back('{1'b0, id_val, cyc + 2});
    $display("req  m0 addr=0 accepted cycle=%0d (after boot)", cyc);
    @(posedge clock); #1;
    m0_read = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int st;
    int a0 [2];
    int a1 [2];
    int b0, b1, x;

    // Reset and boot with a matching slave
    apply_reset();
    boot_seq(1'b1);

    // Continuous contention after reset: first tie already consumed by boot read (m0), so m1 wins first tie
    st = cyc;
    fork
      begin
        do_read(1'b0, 1'b0, id_val, a0[0]);
        do_read(1'b0, 1'b1, TS_VAL, a0[1]);
      end
      begin
        do_read(1'b1, 1'b1, TS_VAL, a1[0]);
        do_read(1'b1, 1'b0, id_val, a1[1]);
      end
    join
    check("cont_m1_first", 32'(a1[0] - st), 32'd0);
    check("cont_m0_second", 32'(a0[0] - st), 32'd3);
    check("cont_m1_third", 32'(a1[1] - st), 32'd6);
    check("cont_m0_fourth", 32'(a0[1] - st), 32'd9);
    repeat (3) @(negedge clock);

    // Single m0 read of the timestamp
    st = cyc;
    do_read(1'b0, 1'b1, TS_VAL, x);
    check("single_accept", 32'(x - st), 32'd0);
    repeat (3) @(negedge clock);

    // m1 arrives while m0 is in BUSY
    st = cyc;
    fork
      do_read(1'b0, 1'b0, id_val, b0);
      begin
        @(negedge clock);
        do_read(1'b1, 1'b1, TS_VAL, b1);
      end
    join
    check("busy_m0_accept", 32'(b0 - st), 32'd0);
    check("busy_m1_accept", 32'(b1 - st), 32'd3);
    repeat (3) @(negedge clock);

    // Wrong ID from the slave: status only, reads still work
    id_val = 32'h1;
    apply_reset();
    boot_seq(1'b0);
    st = cyc;
    do_read(1'b0, 1'b0, 32'h1, x);
    check("mismatch_accept", 32'(x - st), 32'd0);
    repeat (3) @(negedge clock);

    // Reset pulsed while a read is in BUSY: response is dropped, boot reruns
    id_val = 32'd0;
    m0_read = 1'b1; m0_address = 1'b1;
    #1;
    check("pre_busy_grant", 32'(m0_waitrequest), 32'd0);
    @(posedge clock); #1;
    m0_read = 1'b0;
    apply_reset();
    repeat (3) @(negedge clock);
    boot_seq(1'b1);

    repeat (6) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
